// File: rtl/qei_velocity_meter.sv
// Windowed velocity meter for one quadrature-decoder channel: counts per programmable window,
// saturated to VEL_W bits and sign-extended to 32, with clear-aware discard of dirty windows.
module qei_velocity_meter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned VEL_W = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic [31:0]      WINDOW_Set,
  input  logic             QEI_CLEAR,
  input  logic [CNT_W-1:0] QEI_CNT,
  output logic [31:0]      VEL_Read,
  output logic             VEL_VALID,
  output logic [1:0]       VEL_STATUS
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic signed [CNT_W-1:0] VelMax = {{(CNT_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] VelMin = {{(CNT_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      win_len_q, win_len_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] raw_q, raw_d;
  logic             dirty_q, dirty_d;
  logic             pend_q, pend_d;
  logic             pend_dirty_q, pend_dirty_d;

  logic [31:0]      win_len_set;
  logic             close;
  logic             sat_hi, sat_lo;
  logic [VEL_W-1:0] vel_sat;

  assign win_len_set = (WINDOW_Set < 32'd2) ? 32'd2 : WINDOW_Set;
  assign close       = (state_q == StRun) && EN && (timer_q == win_len_q - 32'd1);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    win_len_d    = win_len_q;
    base_d       = base_q;
    raw_d        = raw_q;
    dirty_d      = dirty_q;
    pend_d       = 1'b0;
    pend_dirty_d = pend_dirty_q;
    case (state_q)
      StIdle: begin
        if (EN) begin
          state_d   = StRun;
          base_d    = QEI_CNT;
          timer_d   = '0;
          win_len_d = win_len_set;
          dirty_d   = 1'b0;
        end
      end
      StRun: begin
        if (!EN) begin
          // In-flight window is abandoned; nothing is issued.
          state_d = StIdle;
        end else if (close) begin
          raw_d        = QEI_CNT - base_q;
          base_d       = QEI_CNT;
          timer_d      = '0;
          win_len_d    = win_len_set;
          dirty_d      = 1'b0;
          pend_d       = 1'b1;
          pend_dirty_d = dirty_q | QEI_CLEAR;
        end else begin
          timer_d = timer_q + 32'd1;
          dirty_d = dirty_q | QEI_CLEAR;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sat_hi  = $signed(raw_q) > VelMax;
  assign sat_lo  = $signed(raw_q) < VelMin;
  assign vel_sat = sat_hi ? {1'b0, {(VEL_W-1){1'b1}}} :
                   sat_lo ? {1'b1, {(VEL_W-1){1'b0}}} : raw_q[VEL_W-1:0];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      win_len_q    <= '0;
      base_q       <= '0;
      raw_q        <= '0;
      dirty_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_dirty_q <= 1'b0;
      VEL_Read     <= '0;
      VEL_VALID    <= 1'b0;
      VEL_STATUS   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      win_len_q    <= win_len_d;
      base_q       <= base_d;
      raw_q        <= raw_d;
      dirty_q      <= dirty_d;
      pend_q       <= pend_d;
      pend_dirty_q <= pend_dirty_d;
      VEL_VALID    <= pend_q & ~pend_dirty_q;
      // Result stage: a dirty window only flags the discard; saturation flag keeps its value.
      if (pend_q) begin
        if (!pend_dirty_q) begin
          VEL_Read   <= {{(32-VEL_W){vel_sat[VEL_W-1]}}, vel_sat};
          VEL_STATUS <= {1'b0, sat_hi | sat_lo};
        end else begin
          VEL_STATUS[1] <= 1'b1;
        end
      end
    end
  end

endmodule
